dds2note_seq: RTL and testbench

Sequential inverse of the note-to-DDS increment mapping: accepts a 32-bit DDS phase increment and returns the nearest MIDI note number (0..127) under the same 12-entry base table and octave-shift scheme used by the synth's oscillators. It sits beside the voice allocator for pitch readback, portamento endpoint detection and self-test. It uses a multi-cycle normalize-then-search FSM with a start/valid handshake, not a wide combinational compare tree.

---
 rtl/dds2note_pkg.sv | 31 +++
 rtl/dds2note_bound_rom.sv | 16 +
 rtl/dds2note_seq.sv | 125 ++++++++++++
 tb/tb_dds2note_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds2note_pkg.sv
// Shared constants for mapping DDS phase increments back to MIDI notes:
// oscillator base table, rounding boundaries and converter state encoding.
package dds2note_pkg;

    localparam logic [31:0] BASE_TABLE [12] = '{
        32'd359575, 32'd380957, 32'd403610, 32'd427610, 32'd453037, 32'd479976,
        32'd508516, 32'd538754, 32'd570790, 32'd604731, 32'd640691, 32'd678788
    };

    // Floor of the midpoints between adjacent base entries; b0 sits below B[0],
    // and UPPER_LIMIT sits above B[11].
    localparam logic [31:0] BOUND_TABLE [12] = '{
        32'd349484, 32'd370266, 32'd392283, 32'd415610, 32'd440323, 32'd466506,
        32'd494246, 32'd523635, 32'd554772, 32'd587760, 32'd622711, 32'd659739
    };

    localparam logic [31:0] UPPER_LIMIT = 32'd698969;
    localparam logic [3:0]  NORM_MAX    = 4'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NORM   = 2'd1,
        SEARCH = 2'd2
    } state_t;

    // Note number for octave shift k and semitone i; up to 131, so 8 bits wide.
    function automatic logic [7:0] note_index(input logic [3:0] k, input logic [3:0] i);
        return 8'd12 * (8'd10 - {4'd0, k}) + {4'd0, i};
    endfunction

endpackage

// File: rtl/dds2note_bound_rom.sv
// Combinational lookup of the semitone decision boundary b[j];
// indices 12..15 are unused and read as zero.
module dds2note_bound_rom
    import dds2note_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [31:0] bound
);

    always_comb begin
        bound = '0;
        if (idx < 4'd12)
            bound = BOUND_TABLE[idx];
    end

endmodule

// File: rtl/dds2note_seq.sv
// Sequential increment-to-note converter: normalizes the increment into the
// top octave by doubling, then walks the boundary table downward to pick a semitone.
module dds2note_seq
    import dds2note_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] ADDER,
    output logic [6:0]  NOTE,
    output logic        ERR,
    output logic        VALID,
    output logic        BUSY
);

    state_t      state, state_n;
    logic [31:0] v, v_n;
    logic [3:0]  k, k_n;
    logic [3:0]  j, j_n;
    logic [6:0]  note_n;
    logic        err_n, valid_n, busy_n;
    logic [3:0]  rom_idx;
    logic [31:0] bound;
    logic [7:0]  n_full;

    // NORM only ever needs b0; SEARCH needs b[j].
    assign rom_idx = (state == SEARCH) ? j : 4'd0;
    assign n_full  = note_index(k, j);

    dds2note_bound_rom u_bound_rom (
        .idx   (rom_idx),
        .bound (bound)
    );

    always_comb begin
        state_n = state;
        v_n     = v;
        k_n     = k;
        j_n     = j;
        note_n  = NOTE;
        err_n   = ERR;
        valid_n = 1'b0;
        busy_n  = BUSY;

        unique case (state)
            IDLE: begin
                if (START) begin
                    v_n     = ADDER;
                    k_n     = 4'd0;
                    busy_n  = 1'b1;
                    state_n = NORM;
                end
            end

            NORM: begin
                if (k == 4'd0 && v >= UPPER_LIMIT) begin
                    note_n  = 7'd127;
                    err_n   = 1'b1;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (v < bound) begin
                    if (k < NORM_MAX) begin
                        // v < b0 here, so the shift cannot overflow.
                        v_n = v << 1;
                        k_n = k + 4'd1;
                    end else begin
                        note_n  = 7'd0;
                        err_n   = 1'b1;
                        valid_n = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    j_n     = 4'd11;
                    state_n = SEARCH;
                end
            end

            SEARCH: begin
                if (v >= bound || j == 4'd0) begin
                    if (n_full > 8'd127) begin
                        note_n = 7'd127;
                        err_n  = 1'b1;
                    end else begin
                        note_n = n_full[6:0];
                        err_n  = 1'b0;
                    end
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    j_n = j - 4'd1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            v     <= '0;
            k     <= '0;
            j     <= '0;
            NOTE  <= '0;
            ERR   <= 1'b0;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            v     <= v_n;
            k     <= k_n;
            j     <= j_n;
            NOTE  <= note_n;
            ERR   <= err_n;
            VALID <= valid_n;
            BUSY  <= busy_n;
        end
    end

endmodule

// File: tb/tb_dds2note_seq.sv
// Directed bench for dds2note_seq: latency, rounding boundaries, range errors,
// the full 128-note sweep, busy-time START rejection and mid-conversion reset.
module tb_dds2note_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] ADDER = '0;
    logic [6:0]  NOTE;
    logic        ERR, VALID, BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] BASE [12] = '{
        32'd359575, 32'd380957, 32'd403610, 32'd427610, 32'd453037, 32'd479976,
        32'd508516, 32'd538754, 32'd570790, 32'd604731, 32'd640691, 32'd678788
    };

    dds2note_seq dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .ADDER (ADDER),
        .NOTE  (NOTE),
        .ERR   (ERR),
        .VALID (VALID),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    // One conversion: checks BUSY after accept, VALID latency (elat < 0 skips it),
    // NOTE/ERR, BUSY low with VALID, and VALID dropping after one cycle.
    task automatic do_conversion(input string name, input logic [31:0] a,
                                 input logic [6:0] en, input logic ee, input int elat);
        int lat;
        lat = -1;
        @(negedge CLK);
        START = 1'b1;
        ADDER = a;
        @(posedge CLK); #1;
        START = 1'b0;
        ADDER = $urandom;
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, BUSY);
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (VALID === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL %s timeout: no VALID within 40 cycles", name);
            return;
        end
        if (elat >= 0) begin
            n_checks++;
            if (lat != elat) begin
                n_fail++;
                $display("FAIL %s latency: got E%0d expected E%0d", name, lat, elat);
            end
        end
        n_checks++;
        if (NOTE !== en) begin
            n_fail++;
            $display("FAIL %s note: got %0d expected %0d", name, NOTE, en);
        end
        n_checks++;
        if (ERR !== ee) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, ERR, ee);
        end
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_valid: got %b expected 0", name, BUSY);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (VALID !== 1'b0 || NOTE !== en || ERR !== ee) begin
            n_fail++;
            $display("FAIL %s hold: got valid=%b note=%0d err=%b expected valid=0 note=%0d err=%b",
                     name, VALID, NOTE, ERR, en, ee);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if ({NOTE, ERR, VALID, BUSY} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: got note=%0d err=%b valid=%b busy=%b expected all 0",
                     NOTE, ERR, VALID, BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_test_plan();
        do_conversion("a440",       32'd18897,  7'd69,  1'b0, 9);
        do_conversion("low_ok",     32'd351,    7'd0,   1'b0, 23);
        do_conversion("low_err",    32'd341,    7'd0,   1'b1, 11);
        do_conversion("zero",       32'd0,      7'd0,   1'b1, 11);
        do_conversion("top127",     32'd538754, 7'd127, 1'b0, 6);
        do_conversion("n128",       32'd570790, 7'd127, 1'b1, 5);
        do_conversion("high_err",   32'd698969, 7'd127, 1'b1, 1);
        do_conversion("max_word",   32'hFFFF_FFFF, 7'd127, 1'b1, 1);
    endtask

    task automatic test_boundaries();
        do_conversion("b0_at",      32'd349484, 7'd120, 1'b0, 13);
        do_conversion("b0_below",   32'd349483, 7'd119, 1'b0, 3);
        do_conversion("b7_at",      32'd523635, 7'd127, 1'b0, 6);
        do_conversion("b7_below",   32'd523634, 7'd126, 1'b0, 7);
        do_conversion("b8_at",      32'd554772, 7'd127, 1'b1, 5);
        do_conversion("b11_at",     32'd659739, 7'd127, 1'b1, 2);
        do_conversion("u_below",    32'd698968, 7'd127, 1'b1, 2);
        do_conversion("s3_b4_lo",   32'd55040,  7'd87,  1'b0, 13);
        do_conversion("s3_b4_hi",   32'd55041,  7'd88,  1'b0, 12);
        do_conversion("s3_b9_lo",   32'd73469,  7'd92,  1'b0, 8);
        do_conversion("s3_b9_at",   32'd73470,  7'd93,  1'b0, 7);
    endtask

    task automatic test_sweep();
        logic [31:0] a;
        for (int n = 0; n < 128; n++) begin
            a = BASE[n % 12] >> (10 - n / 12);
            do_conversion($sformatf("sweep%0d", n), a, 7'(n), 1'b0, -1);
        end
    endtask

    task automatic test_busy_ignore();
        int nvalid;
        int lat;
        logic [6:0] first_note;
        logic first_err;
        nvalid = 0;
        lat = -1;
        first_note = '0;
        first_err = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        ADDER = 32'd18897;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (c == 2) begin
                START = 1'b1;
                ADDER = 32'd341;
            end
            if (c == 3)
                START = 1'b0;
            if (VALID === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    first_note = NOTE;
                    first_err = ERR;
                end
            end
        end
        n_checks++;
        if (nvalid != 1) begin
            n_fail++;
            $display("FAIL busy_ignore valid_count: got %0d expected 1", nvalid);
        end
        n_checks++;
        if (lat != 9 || first_note !== 7'd69 || first_err !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore result: got E%0d note=%0d err=%b expected E9 note=69 err=0",
                     lat, first_note, first_err);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit seen;
        seen = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        ADDER = 32'd18897;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (VALID === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL b2b first_timeout: no VALID within 40 cycles");
            return;
        end
        // Re-request during the VALID cycle; the next edge must accept it.
        START = 1'b1;
        ADDER = 32'd538754;
        @(posedge CLK); #1;
        START = 1'b0;
        n_checks++;
        if (BUSY !== 1'b1 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b accept: got busy=%b valid=%b expected busy=1 valid=0", BUSY, VALID);
        end
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (VALID === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat != 6 || NOTE !== 7'd127 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b second: got E%0d note=%0d err=%b expected E6 note=127 err=0",
                     lat, NOTE, ERR);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_midsearch();
        int nvalid;
        nvalid = 0;
        @(negedge CLK);
        START = 1'b1;
        ADDER = 32'd351;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({NOTE, ERR, VALID, BUSY} !== 10'd0) begin
            n_fail++;
            $display("FAIL midsearch_reset: got note=%0d err=%b valid=%b busy=%b expected all 0",
                     NOTE, ERR, VALID, BUSY);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1;
            if (VALID === 1'b1 || BUSY === 1'b1)
                nvalid++;
        end
        n_checks++;
        if (nvalid != 0) begin
            n_fail++;
            $display("FAIL midsearch_no_valid: got %0d active cycles expected 0", nvalid);
        end
        do_conversion("after_reset", 32'd18897, 7'd69, 1'b0, 9);
    endtask

    initial begin
        test_reset();
        test_test_plan();
        test_boundaries();
        test_sweep();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midsearch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
